dino_motion_controller: RTL and testbench

Per-frame motion and pose sequencer for the dino. It converts the player jump input and the global game state into the dino's vertical position (dinoY) and the sprite ROM base address consumed by the dino pixel renderer. It runs in the clk domain and advances only on frame ticks derived from frameClk. It replaces the fixed standing/running pose logic with a full run/jump/dead sequence.

---
 rtl/dino_motion_controller_pkg.sv | 45 ++++
 rtl/dino_motion_controller_frame_tick.sv | 36 +++
 rtl/dino_motion_controller.sv | 204 ++++++++++++++++++++
 tb/tb_dino_motion_controller.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/dino_motion_controller_pkg.sv
// -----------------------------------------------------------------------------
// dino_motion_controller_pkg
// Shared constants and types for the dino per-frame controllers:
//   - game state codes driven by the global game FSM
//   - sprite ROM base addresses for each dino pose
//   - default ground row and the 8-bit screen coordinate type
//   - motion FSM state encoding and the falling-velocity helper
// -----------------------------------------------------------------------------
package dino_motion_controller_pkg;

   // Global game state codes (4-bit bus from the game FSM)
   localparam logic [3:0] GAME_IDLE    = 4'd0;
   localparam logic [3:0] GAME_RUNNING = 4'd1;
   localparam logic [3:0] GAME_OVER    = 4'd2;

   // Screen coordinate: unsigned, y grows downward
   typedef logic [7:0] coord_t;
   typedef logic [8:0] spriteAddr_t;
   typedef logic [4:0] vel_t;

   // Sprite ROM origins for each pose
   localparam spriteAddr_t SPRITE_STAND        = 9'd0;
   localparam spriteAddr_t SPRITE_RUN1         = 9'd120;
   localparam spriteAddr_t SPRITE_RUN2         = 9'd240;
   localparam spriteAddr_t SPRITE_DEAD_DEFAULT = 9'd360;

   localparam coord_t GROUND_Y_DEFAULT = 8'd90;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_ASCEND,
      ST_DESCEND,
      ST_DEAD
   } dinoState_t;

   // Next falling velocity: vel + gravity, saturated at vMax.
   // The sum is formed one bit wider so it cannot wrap before the clamp.
   function automatic vel_t fallVel(input vel_t vel, input vel_t gravity, input vel_t vMax);
      logic [5:0] sum;
      sum = {1'b0, vel} + {1'b0, gravity};
      return (sum > {1'b0, vMax}) ? vMax : sum[4:0];
   endfunction

endpackage

// File: rtl/dino_motion_controller_frame_tick.sv
// -----------------------------------------------------------------------------
// frame_tick_detect
// Registered rising-edge detector turning the frame strobe level into a
// single-clk tick. Holding frameClk high produces exactly one tick.
//
// Ports:
//   clk       in   system clock
//   resetn    in   asynchronous active-low reset
//   frameClk  in   frame strobe level, synchronous to clk
//   tick      out  high for the one clk where frameClk is high and was low
//                  on the previous clk
// -----------------------------------------------------------------------------
module frame_tick_detect (
   input  logic clk,
   input  logic resetn,
   input  logic frameClk,
   output logic tick
);

   logic frameClkQ;

   // NOTE: the reset is in the sensitivity list so every register clears
   // immediately when resetn falls, without waiting for a clock edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         frameClkQ <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all
         // registers see pre-edge values regardless of statement order.
         frameClkQ <= frameClk;
      end
   end

   assign tick = frameClk & ~frameClkQ;

endmodule

// File: rtl/dino_motion_controller.sv
// -----------------------------------------------------------------------------
// dino_motion_controller
// Per-frame motion and pose sequencer for the dino. Converts the jump button
// and global game state into the dino's vertical position and the sprite ROM
// base address used by the pixel renderer. All motion/pose updates happen on
// the clk edge where a frame tick is present.
//
// Optional build macro VARIABLE_JUMP_EN: when defined, releasing jumpReq while
// ascending halves the upward velocity (if above 2) for a short hop. When not
// defined, jump height is fixed and jumpReq is ignored outside RUN.
//
// Ports:
//   clk          in   system clock
//   resetn       in   asynchronous active-low reset
//   frameClk     in   frame strobe level, synchronous to clk
//   gameState    in   [3:0] GAME_IDLE / GAME_RUNNING / GAME_OVER
//   jumpReq      in   jump button level
//   dinoY        out  [7:0] dino top row (y grows downward)
//   spriteBase   out  [8:0] sprite ROM origin: 0 stand, 120 run1, 240 run2,
//                     DEAD_BASE dead
//   airborne     out  high while ascending or descending
//   landedPulse  out  one-clk pulse on landing
// -----------------------------------------------------------------------------
module dino_motion_controller
   import dino_motion_controller_pkg::*;
#(
   parameter coord_t      GROUND_Y  = GROUND_Y_DEFAULT,
   parameter vel_t        JUMP_V0   = 5'd6,
   parameter vel_t        GRAVITY   = 5'd1,
   parameter vel_t        V_MAX     = 5'd8,
   parameter logic [2:0]  ANIM_DIV  = 3'd4,
   parameter spriteAddr_t DEAD_BASE = SPRITE_DEAD_DEFAULT
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        frameClk,
   input  logic [3:0]  gameState,
   input  logic        jumpReq,
   output logic [7:0]  dinoY,
   output logic [8:0]  spriteBase,
   output logic        airborne,
   output logic        landedPulse
);

   localparam logic [2:0] ANIM_RELOAD = ANIM_DIV - 3'd1;

   logic        tick;

   dinoState_t  state, stateNext;
   coord_t      dinoYNext;
   vel_t        vel, velNext;
   spriteAddr_t spriteNext;
   logic [2:0]  animCnt, animNext;
   logic        poseSel, poseNext;
   logic        jumpPending, jumpPendingNext;
   logic        landedNext;
   logic        airborneNext;

   // Working values for the airborne states
   vel_t        velEff;
   vel_t        velFall;
   logic [8:0]  fallSum;

   frame_tick_detect uTick (
      .clk      (clk),
      .resetn   (resetn),
      .frameClk (frameClk),
      .tick     (tick)
   );

   always_comb begin
      // NOTE: every combinational output gets a default before any branch;
      // a path that leaves one unassigned would infer a latch.
      stateNext  = state;
      dinoYNext  = dinoY;
      velNext    = vel;
      spriteNext = spriteBase;
      animNext   = animCnt;
      poseNext   = poseSel;
      landedNext = 1'b0;
      velEff     = vel;
      velFall    = fallVel(vel, GRAVITY, V_MAX);
      fallSum    = {1'b0, dinoY} + {4'b0000, velFall};

      if (tick) begin
         if (gameState == GAME_OVER) begin
            // Game over wins from any state; position and velocity freeze
            stateNext  = ST_DEAD;
            spriteNext = DEAD_BASE;
         end else begin
            unique case (state)
               ST_IDLE: begin
                  if (gameState == GAME_RUNNING) begin
                     stateNext  = ST_RUN;
                     spriteNext = SPRITE_RUN1;
                     animNext   = ANIM_RELOAD;
                     poseNext   = 1'b0;
                  end else begin
                     spriteNext = SPRITE_STAND;
                  end
               end

               ST_RUN: begin
                  // A press on this very clk counts even though jumpPending
                  // has not had a chance to capture it yet.
                  if (jumpPending || jumpReq) begin
                     stateNext  = ST_ASCEND;
                     velNext    = JUMP_V0;
                     spriteNext = SPRITE_STAND;
                  end else if (gameState != GAME_RUNNING) begin
                     stateNext  = ST_IDLE;
                     spriteNext = SPRITE_STAND;
                  end else if (animCnt == 3'd0) begin
                     animNext   = ANIM_RELOAD;
                     poseNext   = ~poseSel;
                     spriteNext = poseSel ? SPRITE_RUN1 : SPRITE_RUN2;
                  end else begin
                     animNext   = animCnt - 3'd1;
                  end
               end

               ST_ASCEND: begin
`ifdef VARIABLE_JUMP_EN
                  // Button released early: cut the remaining rise short
                  if (!jumpReq && (vel > 5'd2)) begin
                     velEff = vel >> 1;
                  end
`endif
                  // Clamp at the top row rather than wrapping
                  dinoYNext = (dinoY < {3'b000, velEff}) ? 8'd0
                                                         : dinoY - {3'b000, velEff};
                  if (velEff <= GRAVITY) begin
                     stateNext = ST_DESCEND;
                     velNext   = 5'd0;
                  end else begin
                     velNext   = velEff - GRAVITY;
                  end
               end

               ST_DESCEND: begin
                  // Sum is 9 bits so a fall near the bottom cannot wrap
                  if (fallSum >= {1'b0, GROUND_Y}) begin
                     dinoYNext  = GROUND_Y;
                     stateNext  = ST_RUN;
                     landedNext = 1'b1;
                     spriteNext = SPRITE_RUN1;
                     animNext   = ANIM_RELOAD;
                     poseNext   = 1'b0;
                  end else begin
                     dinoYNext  = fallSum[7:0];
                     velNext    = velFall;
                  end
               end

               ST_DEAD: begin
                  if (gameState == GAME_IDLE) begin
                     stateNext  = ST_IDLE;
                     dinoYNext  = GROUND_Y;
                     velNext    = 5'd0;
                     spriteNext = SPRITE_STAND;
                  end
               end

               default: begin
                  stateNext  = ST_IDLE;
                  spriteNext = SPRITE_STAND;
               end
            endcase
         end
      end

      // A request is only remembered while running; leaving RUN (including
      // taking the jump) drops it.
      jumpPendingNext = (stateNext == ST_RUN) &&
                        (jumpPending || (jumpReq && (state == ST_RUN)));

      airborneNext = (stateNext == ST_ASCEND) || (stateNext == ST_DESCEND);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_IDLE;
         dinoY       <= GROUND_Y;
         vel         <= 5'd0;
         spriteBase  <= SPRITE_STAND;
         animCnt     <= ANIM_RELOAD;
         poseSel     <= 1'b0;
         jumpPending <= 1'b0;
         landedPulse <= 1'b0;
         airborne    <= 1'b0;
      end else begin
         state       <= stateNext;
         dinoY       <= dinoYNext;
         vel         <= velNext;
         spriteBase  <= spriteNext;
         animCnt     <= animNext;
         poseSel     <= poseNext;
         jumpPending <= jumpPendingNext;
         landedPulse <= landedNext;
         airborne    <= airborneNext;
      end
   end

endmodule

// File: tb/tb_dino_motion_controller.sv
// -----------------------------------------------------------------------------
// tb_dino_motion_controller
// Directed bench for dino_motion_controller (default build, default
// parameters). Inputs change on the falling edge; outputs are sampled on the
// falling edge after the rising edge that updated them.
// -----------------------------------------------------------------------------
module tb_dino_motion_controller;

   logic       clk;
   logic       resetn;
   logic       frameClk;
   logic [3:0] gameState;
   logic       jumpReq;
   logic [7:0] dinoY;
   logic [8:0] spriteBase;
   logic       airborne;
   logic       landedPulse;

   int assertCnt = 0;
   int failCnt   = 0;

   // Hand-computed jump trajectory, one entry per tick after take-off
   int jumpY[12] = '{84, 79, 75, 72, 70, 69, 70, 72, 75, 79, 84, 90};
   // Run animation from IDLE: tick 1 enters RUN, toggles on ticks 5 and 9
   int runSprite[9] = '{120, 120, 120, 120, 240, 240, 240, 240, 120};

   dino_motion_controller dut (
      .clk         (clk),
      .resetn      (resetn),
      .frameClk    (frameClk),
      .gameState   (gameState),
      .jumpReq     (jumpReq),
      .dinoY       (dinoY),
      .spriteBase  (spriteBase),
      .airborne    (airborne),
      .landedPulse (landedPulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCnt++;
      if (observed !== expected) begin
         failCnt++;
         $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // One frame tick: frameClk high for one clk, then low. Returns on the
   // falling edge after the updating rising edge, ready for sampling.
   task automatic frameTick();
      @(negedge clk) frameClk = 1'b1;
      @(negedge clk) frameClk = 1'b0;
   endtask

   // One-clk jump button pulse placed between ticks
   task automatic jumpPulse();
      @(negedge clk) jumpReq = 1'b1;
      @(negedge clk) jumpReq = 1'b0;
   endtask

   initial begin
      resetn    = 1'b0;
      frameClk  = 1'b0;
      gameState = 4'd0;
      jumpReq   = 1'b0;

      // ---- reset state ----
      #12;
      check("rst_dinoY", dinoY, 90);
      check("rst_sprite", spriteBase, 0);
      check("rst_airborne", airborne, 0);
      check("rst_landed", landedPulse, 0);
      @(negedge clk) resetn = 1'b1;

      // ---- idle ticks keep standing pose ----
      frameTick();
      check("idle_sprite", spriteBase, 0);

      // ---- IDLE -> RUN and run animation ----
      gameState = 4'd1;
      for (int i = 0; i < 9; i++) begin
         frameTick();
         check($sformatf("run_sprite_t%0d", i + 1), spriteBase, runSprite[i]);
      end
      check("run_dinoY", dinoY, 90);
      check("run_airborne", airborne, 0);

      // ---- full jump from a pulse between ticks ----
      jumpPulse();
      frameTick();
      check("takeoff_airborne", airborne, 1);
      check("takeoff_sprite", spriteBase, 0);
      check("takeoff_dinoY", dinoY, 90);
      for (int i = 0; i < 12; i++) begin
         frameTick();
         check($sformatf("jump_y_t%0d", i + 1), dinoY, jumpY[i]);
         check($sformatf("jump_air_t%0d", i + 1), airborne, (i < 11) ? 1 : 0);
         check($sformatf("jump_land_t%0d", i + 1), landedPulse, (i == 11) ? 1 : 0);
      end
      check("land_sprite", spriteBase, 120);
      @(negedge clk);
      check("land_pulse_cleared", landedPulse, 0);

      // ---- game over mid-jump, then back to idle ----
      jumpPulse();
      frameTick();
      for (int i = 0; i < 3; i++) frameTick();
      check("pre_dead_dinoY", dinoY, 75);
      gameState = 4'd2;
      frameTick();
      check("dead_dinoY", dinoY, 75);
      check("dead_sprite", spriteBase, 360);
      check("dead_airborne", airborne, 0);
      frameTick();
      check("dead_hold_dinoY", dinoY, 75);
      gameState = 4'd1;
      frameTick();
      check("dead_running_hold", spriteBase, 360);
      gameState = 4'd0;
      frameTick();
      check("revive_dinoY", dinoY, 90);
      check("revive_sprite", spriteBase, 0);

      // ---- frameClk held high gives exactly one update ----
      gameState = 4'd1;
      @(negedge clk) frameClk = 1'b1;
      repeat (50) @(negedge clk);
      frameClk = 1'b0;
      check("hold_sprite", spriteBase, 120);
      for (int i = 0; i < 3; i++) frameTick();
      check("hold_anim_t4", spriteBase, 120);
      frameTick();
      check("hold_anim_t5", spriteBase, 240);

      // ---- jumpReq held through landing re-jumps at once ----
      @(negedge clk) jumpReq = 1'b1;
      frameTick();
      check("hold_jump_takeoff", airborne, 1);
      for (int i = 0; i < 12; i++) frameTick();
      check("hold_jump_land_y", dinoY, 90);
      check("hold_jump_landed", landedPulse, 1);
      check("hold_jump_ground", airborne, 0);
      frameTick();
      check("rejump_airborne", airborne, 1);
      check("rejump_sprite", spriteBase, 0);
      frameTick();
      check("rejump_y1", dinoY, 84);
      jumpReq = 1'b0;
      frameTick();
      frameTick();
      check("rejump_y3", dinoY, 75);

      // ---- asynchronous reset mid-jump ----
      #2 resetn = 1'b0;
      #1;
      check("async_rst_dinoY", dinoY, 90);
      check("async_rst_sprite", spriteBase, 0);
      check("async_rst_airborne", airborne, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
      $finish;
   end

endmodule
